// File: rtl/interleaver_commutator_if.sv
// -----------------------------------------------------------------------------
// interleaver_commutator_if
// Byte-stream handshake bundle for the interleaver commutator.
//   in_valid / in_ready / in_data / in_sync : upstream byte stream
//   out_valid / out_ready / out_data / out_branch : interleaved output stream
// Modports:
//   master : the side that produces input bytes and consumes output bytes
//   slave  : the commutator itself
// -----------------------------------------------------------------------------
interface interleaver_commutator_if #(
  parameter int PTR_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_data;
  logic             in_sync;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_data;
  logic [PTR_W-1:0] out_branch;

  modport master (
    output in_valid, in_data, in_sync, out_ready,
    input  in_ready, out_valid, out_data, out_branch
  );

  modport slave (
    input  in_valid, in_data, in_sync, out_ready,
    output in_ready, out_valid, out_data, out_branch
  );
endinterface

// File: rtl/interleaver_commutator.sv
// -----------------------------------------------------------------------------
// interleaver_commutator
// Input commutator and output selector of a convolutional byte interleaver.
// Each accepted byte is broadcast to the branch delay buffers and the branch
// addressed by a rotating pointer is shifted; the byte that branch pushes out
// (or the input byte itself for the zero-delay branch 0) is captured into a
// single registered, back-pressurable output stage.
//
// Parameters:
//   N_BRANCH : number of branches including zero-delay branch 0 (2..32)
//   PTR_W    : branch pointer width, ceil(log2(N_BRANCH))
// Ports:
//   clk          : clock, rising edge
//   reset        : synchronous active-high reset
//   bus          : handshake bundle (slave modport)
//   buf_en       : one-hot shift enable to the branch buffers (bit 0 unloaded)
//   buf_data_in  : byte broadcast to every branch buffer input
//   buf_data_out : flattened branch outputs, branch k at [8k+7:8k]
//
// Optional feature (macro INTERLEAVER_SYNC_ALIGN_EN):
//   when defined, an accepted byte with in_sync=1 is forced onto branch 0 and
//   the pointer restarts at 1; otherwise in_sync is ignored.
// -----------------------------------------------------------------------------
module interleaver_commutator #(
  parameter int N_BRANCH = 18,
  parameter int PTR_W    = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  interleaver_commutator_if.slave bus,
  output logic [N_BRANCH-1:0]     buf_en,
  output logic [7:0]              buf_data_in,
  input  logic [8*N_BRANCH-1:0]   buf_data_out
);

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       out_data_q, out_data_d;
  logic [PTR_W-1:0] out_branch_q, out_branch_d;

  logic             accept;
  logic             sync_hit;
  logic [PTR_W-1:0] sel_ptr;
  logic [7:0]       branch_byte;

  // Branch 0 is a straight wire, so its buffer slice carries nothing.
  logic [7:0]       slice0_unused;
  assign slice0_unused = buf_data_out[7:0];

  // Single output register: a new byte may enter whenever the current one
  // is absent or leaving this cycle.
  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign buf_data_in  = bus.in_data;

`ifdef INTERLEAVER_SYNC_ALIGN_EN
  assign sync_hit = accept && bus.in_sync;
`else
  logic sync_unused;
  assign sync_unused = bus.in_sync;
  assign sync_hit    = 1'b0;
`endif

  // A sync byte redirects this accept to branch 0; the skipped branches
  // simply see no shift.
  assign sel_ptr = sync_hit ? '0 : ptr_q;

  // Branch output is sampled before the enabling edge shifts that buffer.
  always_comb begin
    branch_byte = bus.in_data;
    for (int k = 1; k < N_BRANCH; k++) begin
      if (sel_ptr == PTR_W'(k)) branch_byte = buf_data_out[8*k +: 8];
    end
  end

  // Reset must also stop the buffers shifting in the same cycle.
  always_comb begin
    buf_en = '0;
    for (int k = 0; k < N_BRANCH; k++) begin
      buf_en[k] = accept && !reset && (sel_ptr == PTR_W'(k));
    end
  end

  always_comb begin
    ptr_d        = ptr_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_branch_d = out_branch_q;
    if (accept) begin
      out_data_d   = branch_byte;
      out_branch_d = sel_ptr;
      out_valid_d  = 1'b1;
      ptr_d        = (sel_ptr == PTR_W'(N_BRANCH-1)) ? '0 : sel_ptr + PTR_W'(1);
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q        <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= 8'h00;
      out_branch_q <= '0;
    end else begin
      ptr_q        <= ptr_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_branch_q <= out_branch_d;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_branch = out_branch_q;

endmodule

// File: tb/tb_interleaver_commutator.sv
// -----------------------------------------------------------------------------
// tb_interleaver_commutator
// Bench for interleaver_commutator with N_BRANCH=3. It models the branch delay
// buffers around the DUT, keeps a per-branch byte history as the reference for
// what each output must be, checks every cycle, and runs directed scenarios
// (reset, basic interleave, back-pressure, reset mid-stream, sync) followed by
// a randomized stream with gaps, stalls and sync markers.
// -----------------------------------------------------------------------------
module tb_interleaver_commutator;
  localparam int N  = 3;
  localparam int PW = 2;
`ifdef INTERLEAVER_SYNC_ALIGN_EN
  localparam bit SYNC_EN = 1'b1;
`else
  localparam bit SYNC_EN = 1'b0;
`endif

  logic           clk;
  logic           reset;
  logic [N-1:0]   buf_en;
  logic [7:0]     buf_data_in;
  logic [8*N-1:0] buf_data_out;

  interleaver_commutator_if #(.PTR_W(PW)) bus ();

  interleaver_commutator #(.N_BRANCH(N), .PTR_W(PW)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .buf_en       (buf_en),
    .buf_data_in  (buf_data_in),
    .buf_data_out (buf_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Branch delay buffers: branch k holds k byte stages, index 0 newest.
  logic [7:0] bufm [N][N];
  always_ff @(posedge clk) begin
    for (int k = 1; k < N; k++) begin
      for (int j = 0; j < N; j++) begin
        if (reset) bufm[k][j] <= 8'h00;
        else if (buf_en[k] && j < k) bufm[k][j] <= (j == 0) ? buf_data_in : bufm[k][j-1];
      end
    end
  end
  always_comb begin
    buf_data_out = '0;
    for (int k = 1; k < N; k++) buf_data_out[8*k +: 8] = bufm[k][k-1];
  end

  // Reference: every byte routed to branch k is appended to that branch's
  // history; the byte it pushes out is the one k entries earlier (zero if the
  // branch has not yet filled since reset).
  logic [7:0]   hist [N][1024];
  int           cnt  [N];
  logic         m_valid;
  logic [7:0]   m_data;
  int           m_branch;
  int           m_ptr;

  initial begin
    int kk;
    m_valid = 1'b0; m_data = 8'h00; m_branch = 0; m_ptr = 0;
    for (int k = 0; k < N; k++) cnt[k] = 0;
    forever begin
      @(posedge clk);
      if (reset) begin
        m_valid = 1'b0; m_data = 8'h00; m_branch = 0; m_ptr = 0;
        for (int k = 0; k < N; k++) cnt[k] = 0;
      end else if (bus.in_valid && (!m_valid || bus.out_ready)) begin
        kk = (SYNC_EN && bus.in_sync) ? 0 : m_ptr;
        hist[kk][cnt[kk]] = bus.in_data;
        m_data   = (cnt[kk] >= kk) ? hist[kk][cnt[kk]-kk] : 8'h00;
        cnt[kk]  = cnt[kk] + 1;
        m_branch = kk;
        m_valid  = 1'b1;
        m_ptr    = (kk + 1) % N;
      end else if (m_valid && bus.out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  // Per-cycle comparison against the reference.
  initial begin
    logic [N-1:0] e;
    int           sel;
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
      if (m_valid) begin
        chk("out_data", 32'(bus.out_data), 32'(m_data));
        chk("out_branch", 32'(bus.out_branch), 32'(m_branch));
      end
      chk("in_ready", 32'(bus.in_ready), 32'(!m_valid || bus.out_ready));
      e   = '0;
      sel = (SYNC_EN && bus.in_sync) ? 0 : m_ptr;
      if (!reset && bus.in_valid && (!m_valid || bus.out_ready)) e[sel] = 1'b1;
      chk("buf_en", 32'(buf_en), 32'(e));
    end
  end

  // Record every completed output transfer.
  logic [7:0]    cap_d [$];
  logic [PW-1:0] cap_b [$];
  logic [7:0]    exp_d [$];
  logic [PW-1:0] exp_b [$];
  initial forever begin
    @(negedge clk);
    if (!reset && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      cap_d.push_back(bus.out_data);
      cap_b.push_back(bus.out_branch);
    end
  end

  task automatic clear_cap();
    cap_d.delete();
    cap_b.delete();
  endtask

  task automatic check_cap(input string nm);
    chk({nm, "_count"}, 32'(cap_d.size()), 32'(exp_d.size()));
    for (int i = 0; i < exp_d.size() && i < cap_d.size(); i++) begin
      chk($sformatf("%s_data[%0d]", nm, i), 32'(cap_d[i]), 32'(exp_d[i]));
      chk($sformatf("%s_branch[%0d]", nm, i), 32'(cap_b[i]), 32'(exp_b[i]));
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; bus.in_valid = 1'b0; bus.in_sync = 1'b0; bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input logic s);
    int n;
    bus.in_valid = 1'b1; bus.in_data = d; bus.in_sync = s; n = 0;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      n++;
      if (n > 50) begin
        vectors++; miscompares++;
        $display("FAIL send_timeout: byte %0h not accepted after %0d cycles", d, n);
        break;
      end
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0; bus.in_sync = 1'b0;
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    logic acc;
    // Reset with a valid byte offered: nothing may shift.
    reset = 1'b1; bus.in_valid = 1'b1; bus.in_data = 8'h55; bus.in_sync = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'h00);
    chk("rst_out_branch", 32'(bus.out_branch), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_buf_en", 32'(buf_en), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0; bus.in_valid = 1'b0;

    // Basic interleave.
    clear_cap();
    for (int i = 1; i <= 9; i++) send(8'(i), 1'b0);
    drain();
    exp_d = '{8'h01, 8'h00, 8'h00, 8'h04, 8'h02, 8'h00, 8'h07, 8'h05, 8'h03};
    exp_b = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
    check_cap("basic");

    // Back-pressure after 0x04 is presented.
    do_reset();
    clear_cap();
    for (int i = 1; i <= 4; i++) send(8'(i), 1'b0);
    bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in_data = 8'h05;
    repeat (4) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_buf_en", 32'(buf_en), 32'd0);
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_out_data", 32'(bus.out_data), 32'h04);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    for (int i = 5; i <= 9; i++) send(8'(i), 1'b0);
    drain();
    check_cap("bp");

    // Reset in the middle of a stream, with a byte offered during reset.
    do_reset();
    for (int i = 1; i <= 5; i++) send(8'(i), 1'b0);
    reset = 1'b1; bus.in_valid = 1'b1; bus.in_data = 8'hEE;
    @(posedge clk);
    #1 reset = 1'b0; bus.in_valid = 1'b0;
    clear_cap();
    send(8'h0A, 1'b0); send(8'h0B, 1'b0); send(8'h0C, 1'b0);
    drain();
    exp_d = '{8'h0A, 8'h00, 8'h00};
    exp_b = '{2'd0, 2'd1, 2'd2};
    check_cap("midrst");

    // Sync marker on the third byte.
    do_reset();
    clear_cap();
    send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b1); send(8'h04, 1'b0);
    drain();
    if (SYNC_EN) begin
      exp_d = '{8'h01, 8'h00, 8'h03, 8'h02};
      exp_b = '{2'd0, 2'd1, 2'd0, 2'd1};
    end else begin
      exp_d = '{8'h01, 8'h00, 8'h00, 8'h04};
      exp_b = '{2'd0, 2'd1, 2'd2, 2'd0};
    end
    check_cap("sync");

    // Randomized stream with input gaps, output stalls and sync markers.
    do_reset();
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk);
      #1;
      if (!bus.in_valid || acc) begin
        bus.in_valid = ($urandom_range(0, 3) != 0);
        bus.in_data  = 8'($urandom);
        bus.in_sync  = ($urandom_range(0, 7) == 0);
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
    end
    bus.in_valid = 1'b0; bus.in_sync = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
